// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin output-port arbiter with credit flow control (optional stats via OUT_ARB_STATS_EN)
module output_port_arbiter #(
    parameter int NUM_IN       = 5,
    parameter int WIDTH_packet = 14,
    parameter int CREDITS      = 4,
    parameter int CNT_W        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_IN-1:0]               in_valid,
    input  logic [NUM_IN*WIDTH_packet-1:0]  in_data,
    output logic [NUM_IN-1:0]               in_ready,
    output logic                            out_valid,
    output logic [WIDTH_packet-1:0]         out_data,
    input  logic                            credit_return,
    output logic [$clog2(CREDITS+1)-1:0]    credit_cnt,
    output logic                            credit_err
`ifdef OUT_ARB_STATS_EN
    ,
    output logic [NUM_IN*CNT_W-1:0]         grant_cnt
`endif
);
    localparam int PW = $clog2(NUM_IN);
    localparam int CW = $clog2(CREDITS+1);

    logic [PW-1:0] rr_ptr, g, idx;
    logic          found, grant;

    // Pick the first requester at or after rr_ptr; reset and empty credits suppress the grant.
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = PW'((32'(rr_ptr) + k) % NUM_IN);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        grant    = found && credit_cnt != '0 && !rst;
        in_ready = grant ? NUM_IN'(1) << g : '0;
    end

    // Output register, round-robin pointer and credit accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            rr_ptr     <= '0;
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            out_valid <= grant;
            if (grant) begin
                out_data <= in_data[g*WIDTH_packet +: WIDTH_packet];
                rr_ptr   <= g == PW'(NUM_IN-1) ? '0 : g + PW'(1);
            end
            if (grant && !credit_return)
                credit_cnt <= credit_cnt - CW'(1);
            else if (!grant && credit_return) begin
                if (credit_cnt == CW'(CREDITS))
                    credit_err <= 1'b1;
                else
                    credit_cnt <= credit_cnt + CW'(1);
            end
        end
    end

`ifdef OUT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_IN];
    for (genvar i = 0; i < NUM_IN; i++) begin : g_stats
        // Saturating per-input grant counter.
        always_ff @(posedge clk) begin
            if (rst)
                cnt[i] <= '0;
            else if (in_ready[i] && cnt[i] != '1)
                cnt[i] <= cnt[i] + CNT_W'(1);
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: table-driven directed bench for output_port_arbiter
module tb_output_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  in_valid = '0;
    logic [69:0] in_data;
    logic [4:0]  in_ready;
    logic        out_valid;
    logic [13:0] out_data;
    logic        credit_return = 1'b0;
    logic [2:0]  credit_cnt;
    logic        credit_err;
`ifdef OUT_ARB_STATS_EN
    logic [79:0] grant_cnt;
`endif
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic [4:0]  v;
        logic        cr;
        logic [4:0]  rdy;
        logic        ov;
        logic [13:0] od;
        logic [2:0]  cc;
        logic        ce;
    } vec_t;
    vec_t tbl[$];

    output_port_arbiter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .credit_return(credit_return), .credit_cnt(credit_cnt), .credit_err(credit_err)
`ifdef OUT_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [4:0] v, logic cr, logic [4:0] rdy,
                                logic ov, logic [13:0] od, logic [2:0] cc, logic ce);
        vec_t t;
        t.rst = r; t.v = v; t.cr = cr; t.rdy = rdy;
        t.ov = ov; t.od = od; t.cc = cc; t.ce = ce;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) in_data[i*14 +: 14] = 14'h0010 + 14'(i);
        //                rst  valid    cr   ready    ov    data    cc  ce
        tbl.push_back(mk(1, 5'h1f, 0, 5'h00, 0, 14'h00, 4, 0)); // reset overrides requests
        tbl.push_back(mk(0, 5'h00, 0, 5'h00, 0, 14'h00, 4, 0));
        tbl.push_back(mk(0, 5'h00, 0, 5'h00, 0, 14'h00, 4, 0));
        tbl.push_back(mk(0, 5'h1f, 1, 5'h01, 0, 14'h00, 4, 0)); // full contention
        tbl.push_back(mk(0, 5'h1f, 1, 5'h02, 1, 14'h10, 4, 0));
        tbl.push_back(mk(0, 5'h1f, 1, 5'h04, 1, 14'h11, 4, 0));
        tbl.push_back(mk(0, 5'h1f, 1, 5'h08, 1, 14'h12, 4, 0));
        tbl.push_back(mk(0, 5'h1f, 1, 5'h10, 1, 14'h13, 4, 0));
        tbl.push_back(mk(0, 5'h1f, 1, 5'h01, 1, 14'h14, 4, 0));
        tbl.push_back(mk(0, 5'h04, 0, 5'h04, 1, 14'h10, 4, 0)); // credit exhaustion
        tbl.push_back(mk(0, 5'h04, 0, 5'h04, 1, 14'h12, 3, 0));
        tbl.push_back(mk(0, 5'h04, 0, 5'h04, 1, 14'h12, 2, 0));
        tbl.push_back(mk(0, 5'h04, 0, 5'h04, 1, 14'h12, 1, 0));
        tbl.push_back(mk(0, 5'h04, 0, 5'h00, 1, 14'h12, 0, 0));
        tbl.push_back(mk(0, 5'h04, 1, 5'h00, 0, 14'h12, 0, 0)); // no credit bypass
        tbl.push_back(mk(0, 5'h04, 0, 5'h04, 0, 14'h12, 1, 0));
        tbl.push_back(mk(0, 5'h04, 0, 5'h00, 1, 14'h12, 0, 0));
        tbl.push_back(mk(0, 5'h00, 1, 5'h00, 0, 14'h12, 0, 0)); // refill
        tbl.push_back(mk(0, 5'h00, 1, 5'h00, 0, 14'h12, 1, 0));
        tbl.push_back(mk(0, 5'h00, 1, 5'h00, 0, 14'h12, 2, 0));
        tbl.push_back(mk(0, 5'h00, 1, 5'h00, 0, 14'h12, 3, 0));
        tbl.push_back(mk(0, 5'h08, 1, 5'h08, 0, 14'h12, 4, 0)); // moves pointer to 4
        tbl.push_back(mk(0, 5'h0a, 1, 5'h02, 1, 14'h13, 4, 0)); // wrap and skip
        tbl.push_back(mk(0, 5'h0a, 1, 5'h08, 1, 14'h11, 4, 0));
        tbl.push_back(mk(0, 5'h0a, 1, 5'h02, 1, 14'h13, 4, 0));
        tbl.push_back(mk(0, 5'h00, 1, 5'h00, 1, 14'h11, 4, 0)); // credit overflow
        tbl.push_back(mk(0, 5'h00, 0, 5'h00, 0, 14'h11, 4, 1));
        tbl.push_back(mk(0, 5'h01, 0, 5'h01, 0, 14'h11, 4, 1));
        tbl.push_back(mk(0, 5'h00, 0, 5'h00, 1, 14'h10, 3, 1));
        tbl.push_back(mk(1, 5'h1f, 0, 5'h00, 0, 14'h10, 3, 1)); // mid-run reset
        tbl.push_back(mk(0, 5'h00, 0, 5'h00, 0, 14'h00, 4, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            in_valid = tbl[i].v;
            credit_return = tbl[i].cr;
            #2;
            n_vec++;
            check("in_ready",   i, 32'(in_ready),   32'(tbl[i].rdy));
            check("out_valid",  i, 32'(out_valid),  32'(tbl[i].ov));
            check("out_data",   i, 32'(out_data),   32'(tbl[i].od));
            check("credit_cnt", i, 32'(credit_cnt), 32'(tbl[i].cc));
            check("credit_err", i, 32'(credit_err), 32'(tbl[i].ce));
        end

`ifdef OUT_ARB_STATS_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 5'h01;
            credit_return = 1'b1;
            #2;
            n_vec++;
            check("stats_ready", 100 + i, 32'(in_ready), 32'h01);
        end
        @(negedge clk);
        in_valid = 5'h00;
        credit_return = 1'b0;
        #2;
        n_vec++;
        check("grant_cnt0", 103, 32'(grant_cnt[15:0]), 32'd3);
        check("grant_cnt_rest", 103, 32'(grant_cnt[79:16] != '0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 5'h1f;
        #2;
        n_vec++;
        check("rst_ready", 104, 32'(in_ready), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 5'h00;
        #2;
        n_vec++;
        check("rst_out_valid", 105, 32'(out_valid), 32'd0);
        check("rst_grant_cnt", 105, 32'(grant_cnt != '0), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Clocked round-robin arbiter with credit-based flow control for one mesh router output port. Shares the output link among NUM_IN input requesters (N, S, E, W, PE), pushes one single-flit packet per cycle into the downstream input buffer, and never overruns that buffer. This block is the synchronous counterpart of the router's per-port output control. It sits between the router's route-compute stage and the output link register.

## Interface
Parameters:
- NUM_IN, 5, number of requesting inputs; index 0 = N, 1 = S, 2 = E, 3 = W, 4 = PE.
- WIDTH_packet, 14, packet width in bits.
- CREDITS, 4, downstream buffer depth; initial credit count.
- CNT_W, 16, grant-counter width; used only with OUT_ARB_STATS_EN.

Ports:
- clk, in, 1, the single clock; all state updates on posedge.
- rst, in, 1, reset; synchronous, active-high.
- in_valid, in, NUM_IN, per-input request.
- in_data, in, NUM_IN*WIDTH_packet, per-input packet; input i occupies bits [i*WIDTH_packet +: WIDTH_packet].
- in_ready, out, NUM_IN, one-hot-or-zero combinational grant.
- out_valid, out, 1, registered push strobe to the downstream buffer.
- out_data, out, WIDTH_packet, registered packet.
- credit_return, in, 1, one-cycle pulse from downstream; each pulse frees one buffer slot.
- credit_cnt, out, $clog2(CREDITS+1), current credits.
- credit_err, out, 1, sticky flag for credit overflow.
- grant_cnt, out, NUM_IN*CNT_W, per-input grant counters; present only with OUT_ARB_STATS_EN.

## Operation
- State:
  - rr_ptr, width $clog2(NUM_IN), reset 0.
  - credit_cnt, reset CREDITS.
  - out_valid/out_data registers.
  - credit_err.
- Grant condition:
  - Grant when credit_cnt > 0 and any in_valid is high.
  - Winner g = first i with in_valid[i] high, scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_IN.
  - in_ready[g] = 1; all other in_ready = 0.
  - If credit_cnt == 0 or no request, in_ready = 0.
- On a grant (posedge):
  - out_data <= in_data[g] and out_valid <= 1.
  - rr_ptr <= (g == NUM_IN-1) ? 0 : g+1.
- With no grant:
  - out_valid <= 0 and out_data holds its value.
  - rr_ptr holds.
- Credit update per cycle, with grant = in_ready != 0:
  - Grant and credit_return together: credit_cnt unchanged.
  - Grant only: credit_cnt - 1.
  - credit_return only: credit_cnt + 1.
  - credit_return while credit_cnt == CREDITS and no grant: count stays at CREDITS and credit_err <= 1 (sticky until rst).
- No credit bypass: a credit returned in cycle t can enable a grant only from cycle t+1 onward, and only when credit_cnt was 0.
- Requesters hold in_valid and in_data stable until they see in_ready. The arbiter does not sample a dropped request.

## Timing
- Reset values:
  - in_ready = 0 while rst is asserted; this overrides grant logic.
  - out_valid = 0, out_data = 0.
  - credit_cnt = CREDITS, rr_ptr = 0, credit_err = 0.
  - grant_cnt = 0.
- Latency: a request accepted in cycle t (in_valid & in_ready) appears as out_valid/out_data in cycle t+1.
- Throughput: one packet per cycle while credits last. After CREDITS back-to-back grants with no returns, in_ready stays 0 until a credit_return.
- Fairness:
  - With all NUM_IN inputs continuously requesting and ample credits, grants go 0, 1, 2, 3, 4, 0, …
  - No input waits more than NUM_IN-1 grants.
- Reset mid-operation: rst in cycle t discards any grant in that cycle. State returns to reset values at posedge t+1, and no out_valid is emitted for the discarded packet.
- in_ready depends combinationally on in_valid, rr_ptr and credit_cnt. It never depends combinationally on credit_return.

## Configuration
- OUT_ARB_STATS_EN defined:
  - grant_cnt port and per-input counters exist.
  - Counter i increments on each cycle input i is granted.
  - Counters saturate at 2^CNT_W-1 and clear on rst.
- OUT_ARB_STATS_EN undefined: the grant_cnt port and its counters are not present. All other behaviour is identical.

## Test plan
- Reset then idle:
  - Stimulus: hold rst 2 cycles, then drive no requests.
  - Required: out_valid = 0, credit_cnt = 4, in_ready = 5'b00000 every cycle.
- Full contention:
  - Stimulus: all 5 inputs valid with data 14'h0010+i; credit_return pulsed each cycle.
  - Required: grant order 0, 1, 2, 3, 4, 0 on in_ready; out_data 0x10, 0x11, 0x12, … one cycle later; credit_cnt stays at 4 throughout.
- Credit exhaustion:
  - Stimulus: input 2 valid continuously, no credit_return.
  - Required: exactly 4 grants; then in_ready = 0 and credit_cnt = 0.
  - Stimulus: one credit_return pulse in cycle t.
  - Required: grant in cycle t+1, then credit_cnt = 0 again.
- Wrap and skip:
  - Stimulus: rr_ptr at 4 with only inputs 1 and 3 valid.
  - Required: input 1 granted, then input 3, then input 1.
- Credit overflow:
  - Stimulus: credit_return at credit_cnt = 4 with no grant.
  - Required: credit_cnt stays 4, credit_err = 1, and it stays 1 until rst.
- Stats and mid-run reset:
  - Stimulus: with OUT_ARB_STATS_EN, grant input 0 three times; then assert rst during a grant.
  - Required: grant_cnt[0] = 3 before reset; after reset all counters = 0; no out_valid for the discarded grant.
